cordic_angle_prereduce: RTL and testbench

Upstream stage of the CORDIC rotation-mode sine/cosine core. It accepts an arbitrary signed angle in degrees and reduces it modulo 360 to (-180, +180]. It then folds that result into the CORDIC convergence range [-90, +90]. It outputs the folded angle in the core's Q8.12 degree format, plus a flag telling the downstream post-stage to negate cosine. Sine needs no correction.

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_angle_prereduce.sv | 93 +++++++++
 tb/tb_cordic_angle_prereduce.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sine/cosine datapath: Q-format widths,
// integer-degree constants, the core angle type and the pre-reduce FSM states.
package cordic_pkg;

    localparam int FRAC_W  = 12;
    localparam int THETA_W = 24;
    localparam int ANGLE_W = 20;

    localparam logic signed [THETA_W-1:0] D90      = 24'sd368640;
    localparam logic signed [THETA_W-1:0] D180     = 24'sd737280;
    localparam logic signed [THETA_W-1:0] D360     = 24'sd1474560;
    localparam logic signed [THETA_W-1:0] NEG_D90  = -D90;
    localparam logic signed [THETA_W-1:0] NEG_D180 = -D180;

    typedef logic signed [ANGLE_W-1:0] angle_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        FOLD   = 2'd2,
        DONE   = 2'd3
    } prereduce_state_t;

    typedef struct packed {
        angle_t angle;
        logic   cos_neg;
    } fold_t;

    // Mirrors an angle in (-180, +180] about +-90 so sine is unchanged and
    // cosine flips sign; the result always fits the core's Q8.12 range.
    function automatic fold_t fold_to_half_pi(input logic signed [THETA_W-1:0] theta);
        logic signed [THETA_W-1:0] folded;
        fold_t                     result;
        folded         = theta;
        result.cos_neg = 1'b0;
        if (theta > D90) begin
            folded         = D180 - theta;
            result.cos_neg = 1'b1;
        end else if (theta < NEG_D90) begin
            folded         = NEG_D180 - theta;
            result.cos_neg = 1'b1;
        end
        result.angle = angle_t'(folded);
        return result;
    endfunction

endpackage

// File: rtl/cordic_angle_prereduce.sv
// Reduces an arbitrary Q12.12 degree angle to (-180, +180] by repeated +-360
// steps, then folds it into [-90, +90] with a cosine-negate flag for the core.
module cordic_angle_prereduce #(
    parameter int IN_W   = cordic_pkg::THETA_W,
    parameter int OUT_W  = cordic_pkg::ANGLE_W,
    parameter int FRAC_W = cordic_pkg::FRAC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_angle,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_angle,
    output logic             out_cos_neg,
    output logic             out_valid,
    input  logic             out_ready
);
    import cordic_pkg::*;

    localparam logic signed [IN_W-1:0] LIM_POS = IN_W'(180 << FRAC_W);
    localparam logic signed [IN_W-1:0] LIM_NEG = -LIM_POS;
    localparam logic signed [IN_W-1:0] TURN    = IN_W'(360 << FRAC_W);

    prereduce_state_t        state_reg, state_next;
    logic signed [IN_W-1:0]  theta_reg, theta_next;
    logic [OUT_W-1:0]        out_angle_reg, out_angle_next;
    logic                    cos_neg_reg, cos_neg_next;
    logic                    out_valid_reg, out_valid_next;
    fold_t                   fold_res;

    assign fold_res = fold_to_half_pi(theta_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            theta_reg     <= '0;
            out_angle_reg <= '0;
            cos_neg_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            theta_reg     <= theta_next;
            out_angle_reg <= out_angle_next;
            cos_neg_reg   <= cos_neg_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        theta_next     = theta_reg;
        out_angle_next = out_angle_reg;
        cos_neg_next   = cos_neg_reg;
        out_valid_next = out_valid_reg;
        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    theta_next = signed'(in_angle);
                    state_next = REDUCE;
                end
            end
            REDUCE: begin
                // One +-360 step per cycle keeps the adder single and the path short.
                if (theta_reg > LIM_POS) begin
                    theta_next = theta_reg - TURN;
                end else if (theta_reg <= LIM_NEG) begin
                    theta_next = theta_reg + TURN;
                end else begin
                    state_next = FOLD;
                end
            end
            FOLD: begin
                out_angle_next = OUT_W'(fold_res.angle);
                cos_neg_next   = fold_res.cos_neg;
                out_valid_next = 1'b1;
                state_next     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_angle   = out_angle_reg;
    assign out_cos_neg = cos_neg_reg;
    assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_cordic_angle_prereduce.sv
// Directed-vector bench for cordic_angle_prereduce: latency, fold results,
// boundary angles, output back-pressure and asynchronous reset abort.
module tb_cordic_angle_prereduce;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] in_angle = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] out_angle;
    logic        out_cos_neg;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    cordic_angle_prereduce dut (
        .clk         (clk),
        .reset       (reset),
        .in_angle    (in_angle),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_angle   (out_angle),
        .out_cos_neg (out_cos_neg),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one angle and checks latency, result and handshake. stall > 0
    // holds out_ready low for that many cycles while offering a bogus angle.
    task automatic run_txn(input logic [23:0] a, input logic [19:0] exp_angle,
                           input logic exp_cos, input int exp_lat, input int stall);
        int          edges;
        logic [19:0] held_angle;
        @(negedge clk);
        in_angle  = a;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        check("ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ready_busy", 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 32'(edges), 32'(exp_lat));
        check("angle", 32'(out_angle), 32'(exp_angle));
        check("cos_neg", 32'(out_cos_neg), 32'(exp_cos));
        held_angle = out_angle;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_angle = 24'h01E000;
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_angle", 32'(out_angle), 32'(held_angle));
            check("stall_cos", 32'(out_cos_neg), 32'(exp_cos));
            check("stall_ready", 32'(in_ready), 32'd0);
        end
        if (stall > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("hs_valid_clear", 32'(out_valid), 32'd0);
        check("hs_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("idle_no_result", 32'(out_valid), 32'd0);
        $display("txn in=0x%06h out=0x%05h cos_neg=%0d latency=%0d", a, held_angle, out_cos_neg, edges);
    endtask

    initial begin
        int stale;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_angle", 32'(out_angle), 32'd0);
        check("rst_cos", 32'(out_cos_neg), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        run_txn(24'h02D000, 20'h2D000, 1'b0, 2, 0);   //   45 -> 45
        run_txn(24'h087000, 20'h2D000, 1'b1, 2, 0);   //  135 -> 45, neg
        run_txn(24'hF79000, 20'hD3000, 1'b1, 2, 0);   // -135 -> -45, neg
        run_txn(24'h190000, 20'h28000, 1'b0, 3, 0);   //  400 -> 40
        run_txn(24'hF38000, 20'h14000, 1'b1, 3, 0);   // -200 -> 160 -> 20, neg
        run_txn(24'h0B4000, 20'h00000, 1'b1, 2, 0);   //  180 -> 0, neg
        run_txn(24'hF4C000, 20'h00000, 1'b1, 3, 0);   // -180 -> 180 -> 0, neg
        run_txn(24'h05A000, 20'h5A000, 1'b0, 2, 0);   //   90 unchanged
        run_txn(24'hFA6000, 20'hA6000, 1'b0, 2, 0);   //  -90 unchanged
        run_txn(24'h7FF000, 20'hBD000, 1'b1, 8, 5);   // 2047 -> -113 -> -67, neg

        // Abort a -2048 transaction mid-REDUCE with an asynchronous reset.
        @(negedge clk);
        in_angle = 24'h800000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_angle", 32'(out_angle), 32'h000BD000);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_angle", 32'(out_angle), 32'd0);
        check("arst_cos", 32'(out_cos_neg), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) stale++;
        end
        check("no_stale_result", 32'(stale), 32'd0);
        $display("txn in=0x800000 aborted by reset");

        run_txn(24'h01E000, 20'h1E000, 1'b0, 2, 0);   //   30 -> 30

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
